lib_counter_snapshot_reader: RTL and testbench
==============================================

// Module: lib_counter_snapshot_reader
//
// PURPOSE
// Read side for wide multicycle event counters. Waits out the counter's
// pipeline latency, captures its value coherently, computes the delta since the
// previous capture, and serves both through a narrow word-serial read port.
// Sits between lib counters and the AFU CSR block, so software sees
// tear-free 64-bit counts over 32-bit CSR reads.
//
// PARAMETERS
// NUM_BITS      64  width of counter_value, snapshot and delta
// RD_BITS       32  width of rd_data; NUM_WORDS = ceil(NUM_BITS/RD_BITS)
// SETTLE_CYCLES 2   cycles between snap_req acceptance and capture (>=1);
//                   covers the counter's input-to-value latency
//
// PORTS
// clk            in   1          clock
// reset_n        in   1          async active-low reset
// counter_value  in   NUM_BITS   value output of the counter being read
// snap_req       in   1          request a capture (single-cycle pulse or level)
// snap_busy      out  1          capture in progress; snap_req ignored
// snap_done      out  1          one-cycle pulse: snapshot/delta updated
// rd_req         in   1          read request, one word per cycle
// rd_sel         in   1          0 = snapshot, 1 = delta
// rd_word        in   $clog2(NUM_WORDS)+1  word index, 0 = least significant
// rd_valid       out  1          read response valid
// rd_data        out  RD_BITS    read response word
//
// BEHAVIOUR
// - Reset is asynchronous and active-low: the FSM goes to IDLE and snap_busy,
//   snap_done, rd_valid, rd_data, snapshot, prev and delta all clear to 0.
// - FSM states:
//   - IDLE: snap_req=1 -> SETTLE, load settle_cnt=SETTLE_CYCLES-1,
//     snap_busy=1 from the next cycle.
//   - SETTLE: settle_cnt counts down; at 0 -> CAPTURE.
//   - CAPTURE (1 cycle): snapshot<=counter_value;
//     delta<=counter_value-prev (mod 2^NUM_BITS, wrap gives the correct delta);
//     prev<=counter_value; snap_done=1 next cycle; -> IDLE, snap_busy=0.
// - Capture latency: snap_req in cycle T -> counter_value sampled in cycle
//   T+SETTLE_CYCLES+1; snap_done high in T+SETTLE_CYCLES+2.
// - snap_req while snap_busy is dropped, not queued. snap_req in the cycle
//   snap_done is high is accepted.
// - The first capture after reset reports delta = full value (prev = 0).
// - Read port: rd_req in cycle T -> rd_valid=1 with rd_data in T+1; back-to-back
//   reads supported.
//   - rd_data = selected register bits [rd_word*RD_BITS +: RD_BITS].
//   - The top partial word is zero-extended; rd_word >= NUM_WORDS returns 0.
//   - rd_valid=0 cycles drive rd_data=0.
// - Read/capture collision: a read sampled in the CAPTURE cycle returns the
//   pre-capture registers. Software must wait for snap_done before reading a
//   new snapshot.
// - All words of a snapshot come from one capture cycle (no tearing between
//   words).
// - Reset asserted mid-SETTLE: the pending capture is discarded and no
//   snap_done is issued.
//
// TESTING
// - Reset, then rd_req sel=0 word=0/1 -> rd_valid next cycle, rd_data=0 both.
// - counter_value=64'h0000_0001_FFFF_FFF0 held, snap_req pulse ->
//   snap_done at T+4; words read 32'hFFFF_FFF0, 32'h1; delta equals the
//   snapshot.
// - Second capture at 64'h0000_0002_0000_0010 -> delta = 64'h20, word1 = 0.
// - Wrap: prev=64'hFFFF_FFFF_FFFF_FFF8, next=64'h8 -> delta=64'h10.
// - snap_req held 6 cycles -> exactly 2 captures (T, T+4); busy-cycle
//   requests dropped.
// - reset_n low in SETTLE -> no snap_done; snapshot=0; next capture's delta
//   is the full value.

Source files
------------

// File: rtl/lib_counter_snapshot_reader.sv
// Coherent snapshot/delta capture of a wide multicycle counter, served to software
// as narrow word-serial reads so 64-bit counts never tear across 32-bit CSR reads.
module lib_counter_snapshot_reader #(
  parameter int unsigned NUM_BITS      = 64,
  parameter int unsigned RD_BITS       = 32,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned NUM_WORDS    = (NUM_BITS + RD_BITS - 1) / RD_BITS,
  localparam int unsigned WORD_BITS    = $clog2(NUM_WORDS) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_BITS-1:0]  counter_value,
  input  logic                 snap_req,
  output logic                 snap_busy,
  output logic                 snap_done,
  input  logic                 rd_req,
  input  logic                 rd_sel,
  input  logic [WORD_BITS-1:0] rd_word,
  output logic                 rd_valid,
  output logic [RD_BITS-1:0]   rd_data
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StSettle, StCapture} state_e;

  state_e              state_q;
  logic [CntW-1:0]     settle_cnt_q;
  logic [NUM_BITS-1:0] snapshot;
  logic [NUM_BITS-1:0] prev;
  logic [NUM_BITS-1:0] delta;

  logic [NUM_WORDS*RD_BITS-1:0] rd_src;
  logic [RD_BITS-1:0]           rd_word_data;

  // Top partial word is zero-extended; out-of-range word indices fall through to 0.
  always_comb begin
    rd_src                = '0;
    rd_src[NUM_BITS-1:0]  = rd_sel ? delta : snapshot;
    rd_word_data          = '0;
    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      if (rd_word == WORD_BITS'(w)) begin
        rd_word_data = rd_src[w*RD_BITS +: RD_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      snap_busy    <= 1'b0;
      snap_done    <= 1'b0;
      snapshot     <= '0;
      prev         <= '0;
      delta        <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      snap_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (snap_req) begin
            state_q      <= StSettle;
            settle_cnt_q <= CntW'(SETTLE_CYCLES - 1);
            snap_busy    <= 1'b1;
          end
        end
        StSettle: begin
          if (settle_cnt_q == '0) begin
            state_q <= StCapture;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end
        StCapture: begin
          // Modular subtraction yields the correct delta across counter wrap.
          snapshot  <= counter_value;
          delta     <= counter_value - prev;
          prev      <= counter_value;
          snap_done <= 1'b1;
          snap_busy <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Reads see the registers as they were before this edge's capture.
      rd_valid <= rd_req;
      rd_data  <= rd_req ? rd_word_data : '0;
    end
  end

endmodule

// File: tb/tb_lib_counter_snapshot_reader.sv
// Scoreboard bench: read stimulus queues expected words, a negedge monitor checks
// every rd_valid response and counts snap_done pulses.
module tb_lib_counter_snapshot_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] counter_value = '0;
  logic        snap_req = 1'b0;
  logic        snap_busy;
  logic        snap_done;
  logic        rd_req = 1'b0;
  logic        rd_sel = 1'b0;
  logic [1:0]  rd_word = '0;
  logic        rd_valid;
  logic [31:0] rd_data;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  lib_counter_snapshot_reader #(
    .NUM_BITS     (64),
    .RD_BITS      (32),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .counter_value(counter_value),
    .snap_req     (snap_req),
    .snap_busy    (snap_busy),
    .snap_done    (snap_done),
    .rd_req       (rd_req),
    .rd_sel       (rd_sel),
    .rd_word      (rd_word),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation for every valid response, idle data must be 0.
  always @(negedge clk) begin
    if (snap_done === 1'b1) done_cnt++;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_valid", 64'd1, 64'd0);
      end else begin
        check("rd_data", {32'd0, rd_data}, {32'd0, exp_q.pop_front()});
      end
    end else begin
      check("rd_idle_data", {32'd0, rd_data}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic sel, input logic [1:0] word, input logic [31:0] exp);
    rd_req  = 1'b1;
    rd_sel  = sel;
    rd_word = word;
    exp_q.push_back(exp);
    tick();
    rd_req = 1'b0;
  endtask

  // Pulse snap_req and check busy/done timing: done exactly T+4.
  task automatic do_snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check("busy_after_accept", {63'd0, snap_busy}, 64'd1);
    repeat (2) tick();
    check("done_early", {63'd0, snap_done}, 64'd0);
    tick();
    check("done_pulse", {63'd0, snap_done}, 64'd1);
    check("busy_cleared", {63'd0, snap_busy}, 64'd0);
    tick();
    check("done_one_cycle", {63'd0, snap_done}, 64'd0);
  endtask

  int base;

  initial begin
    repeat (2) tick();
    check("reset_busy", {63'd0, snap_busy}, 64'd0);
    check("reset_done", {63'd0, snap_done}, 64'd0);
    check("reset_valid", {63'd0, rd_valid}, 64'd0);
    reset_n = 1'b1;
    tick();
    rd(1'b0, 2'd0, 32'h0);
    rd(1'b0, 2'd1, 32'h0);
    rd(1'b1, 2'd0, 32'h0);
    tick();

    // First capture: delta equals full value.
    counter_value = 64'h0000_0001_FFFF_FFF0;
    do_snap();
    rd(1'b0, 2'd0, 32'hFFFF_FFF0);
    rd(1'b0, 2'd1, 32'h0000_0001);
    rd(1'b1, 2'd0, 32'hFFFF_FFF0);
    rd(1'b1, 2'd1, 32'h0000_0001);
    rd(1'b0, 2'd2, 32'h0);
    rd(1'b0, 2'd3, 32'h0);
    tick();

    counter_value = 64'h0000_0002_0000_0010;
    do_snap();
    rd(1'b1, 2'd0, 32'h0000_0020);
    rd(1'b1, 2'd1, 32'h0);
    rd(1'b0, 2'd0, 32'h0000_0010);
    rd(1'b0, 2'd1, 32'h0000_0002);
    tick();

    // Wrap-around delta.
    counter_value = 64'hFFFF_FFFF_FFFF_FFF8;
    do_snap();
    rd(1'b1, 2'd1, 32'hFFFF_FFFD);
    rd(1'b1, 2'd0, 32'hFFFF_FFE8);
    counter_value = 64'h8;
    do_snap();
    rd(1'b1, 2'd0, 32'h0000_0010);
    rd(1'b1, 2'd1, 32'h0);
    rd(1'b0, 2'd1, 32'h0);
    tick();

    // Read sampled in the CAPTURE cycle returns the old delta.
    counter_value = 64'h100;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    repeat (2) tick();
    rd(1'b1, 2'd0, 32'h0000_0010);
    check("collision_done", {63'd0, snap_done}, 64'd1);
    rd(1'b1, 2'd0, 32'h0000_00F8);
    tick();

    // snap_req held 6 cycles: accepted at T and T+4 only.
    base = done_cnt;
    counter_value = 64'h1000;
    snap_req = 1'b1;
    repeat (4) tick();
    counter_value = 64'h1500;
    repeat (2) tick();
    snap_req = 1'b0;
    repeat (6) tick();
    check("held_req_captures", 64'(done_cnt - base), 64'd2);
    rd(1'b1, 2'd0, 32'h0000_0500);
    rd(1'b0, 2'd0, 32'h0000_1500);
    tick();

    // Reset during SETTLE discards the pending capture.
    base = done_cnt;
    counter_value = 64'h2222;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    repeat (5) tick();
    check("reset_settle_no_done", 64'(done_cnt - base), 64'd0);
    check("reset_settle_busy", {63'd0, snap_busy}, 64'd0);
    rd(1'b0, 2'd0, 32'h0);
    rd(1'b1, 2'd0, 32'h0);
    counter_value = 64'h3333_0000_0000_0005;
    do_snap();
    rd(1'b1, 2'd0, 32'h0000_0005);
    rd(1'b1, 2'd1, 32'h3333_0000);
    repeat (3) tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
